// File: rtl/fan_speed_ramp.sv
// fan_speed_ramp: turns a 2-bit speed level plus enable into a slew-limited PWM duty.
// Ports: clk; reset_n async active-low; enable/level select the target duty;
// duty drives the PWM generator; busy is high in KICK/RAMP, at_target in IDLE/HOLD.
module fan_speed_ramp #(
    parameter int N          = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int STEP_HZ    = 1000,
    parameter int STEP       = 1,
    parameter int KICK_TICKS = 200,
    parameter int LVL1       = 85,
    parameter int LVL2       = 170,
    parameter int LVL3       = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [1:0]   level,
    output logic [N-1:0] duty,
    output logic         busy,
    output logic         at_target
);
    localparam int TP = CLK_FREQ / STEP_HZ;
    localparam int PW = TP > 1 ? $clog2(TP) : 1;
    localparam int KW = $clog2(KICK_TICKS + 2);

    typedef enum logic [1:0] {IDLE, KICK, RAMP, HOLD} state_t;

    state_t        state, state_nx;
    logic [PW-1:0] pcnt;
    logic [KW-1:0] kcnt, kcnt_nx;
    logic [N-1:0]  target, duty_nx, ramp_val;
    logic [N:0]    up, dn;
    logic          tick, kick_done, busy_nx;

    assign target = (!enable || level == 2'd0) ? '0 :
                    level == 2'd1 ? N'(LVL1) :
                    level == 2'd2 ? N'(LVL2) : N'(LVL3);

    assign tick      = pcnt == PW'(TP - 1);
    assign kick_done = tick && (kcnt + KW'(1) == KW'(KICK_TICKS));

    // One extra bit catches overflow past 2^N-1 and underflow below 0,
    // so both directions clamp to the target instead of wrapping.
    assign up       = {1'b0, duty} + (N+1)'(STEP);
    assign dn       = {1'b0, duty} - (N+1)'(STEP);
    assign ramp_val = duty < target ? (up > {1'b0, target} ? target : up[N-1:0]) :
                      duty > target ? ((dn[N] || dn[N-1:0] < target) ? target : dn[N-1:0]) :
                      duty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            duty      <= '0;
            busy      <= 1'b0;
            at_target <= 1'b1;
            pcnt      <= '0;
            kcnt      <= '0;
        end else begin
            state     <= state_nx;
            duty      <= duty_nx;
            busy      <= busy_nx;
            at_target <= !busy_nx;
            pcnt      <= tick ? '0 : pcnt + PW'(1);
            kcnt      <= kcnt_nx;
        end
    end

    // Dropping the target during the kick hands over to RAMP so the motor
    // slews down from full duty rather than being cut.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (target != '0) state_nx = KICK_TICKS > 0 ? KICK : RAMP;
            KICK: if (target == '0 || kick_done) state_nx = RAMP;
            RAMP: if (duty == target) state_nx = target == '0 ? IDLE : HOLD;
            HOLD: if (duty != target) state_nx = RAMP;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        duty_nx = state_nx == KICK ? '1 : (state == RAMP && tick) ? ramp_val : duty;
        kcnt_nx = state != KICK ? '0 : tick ? kcnt + KW'(1) : kcnt;
        busy_nx = state_nx == KICK || state_nx == RAMP;
    end
endmodule

// File: tb/tb_fan_speed_ramp.sv
// tb_fan_speed_ramp: directed bench for fan_speed_ramp with a 4-clock tick, STEP=16, 3-tick kick.
module tb_fan_speed_ramp;
    logic       clk;
    logic       reset_n;
    logic       enable;
    logic [1:0] level;
    logic [7:0] duty;
    logic       busy;
    logic       at_target;
    int         checks;
    int         failures;

    int down1[11] = '{239, 223, 207, 191, 175, 159, 143, 127, 111, 95, 85};
    int up1[6]    = '{101, 117, 133, 149, 165, 170};
    int up2[6]    = '{186, 202, 218, 234, 250, 255};
    int dis1[8]   = '{239, 223, 207, 191, 175, 159, 143, 127};
    int dis2[8]   = '{111, 95, 79, 63, 47, 31, 15, 0};
    int lvl2[6]   = '{239, 223, 207, 191, 175, 170};

    fan_speed_ramp #(
        .N(8), .CLK_FREQ(1000), .STEP_HZ(250), .STEP(16), .KICK_TICKS(3),
        .LVL1(85), .LVL2(170), .LVL3(255)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .level(level),
        .duty(duty),
        .busy(busy),
        .at_target(at_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (obs >= lo && obs <= hi) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic chk_out(input string tag, input int d, input logic b);
        chk({tag, " duty"}, duty, d);
        chk({tag, " busy"}, busy, b);
        chk({tag, " at_target"}, at_target, !b);
    endtask

    // Waits (bounded) for duty to change, then checks the new value and how many clocks it took.
    task automatic wait_duty(input string tag, input int exp, input int lo, input int hi);
        logic [7:0] old;
        int n;
        old = duty;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (duty === old && n < 40);
        chk({tag, " value"}, duty, exp);
        chk_rng({tag, " gap"}, n, lo, hi);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset_n = 1'b0;
        enable = 1'b1;
        level = 2'd3;
        repeat (3) begin
            @(negedge clk);
            chk_out("reset hold", 0, 1'b0);
        end
        reset_n = 1'b1;
        #1 chk_out("after release", 0, 1'b0);
        @(negedge clk);
        chk_out("first edge kick", 255, 1'b1);

        reset_n = 1'b0;
        enable = 1'b0;
        level = 2'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_out("idle", 0, 1'b0);

        enable = 1'b1;
        level = 2'd1;
        @(negedge clk);
        chk_out("kick", 255, 1'b1);
        for (int i = 0; i < 11; i++)
            wait_duty("ramp to 85", down1[i], i == 0 ? 13 : 4, i == 0 ? 16 : 4);
        chk("ramp end busy", busy, 1'b1);
        @(negedge clk);
        chk_out("hold 85", 85, 1'b0);

        level = 2'd2;
        for (int i = 0; i < 6; i++)
            wait_duty("ramp to 170", up1[i], i == 0 ? 2 : 4, i == 0 ? 5 : 4);
        @(negedge clk);
        chk_out("hold 170", 170, 1'b0);

        level = 2'd3;
        for (int i = 0; i < 6; i++)
            wait_duty("sat up", up2[i], i == 0 ? 2 : 4, i == 0 ? 5 : 4);
        @(negedge clk);
        chk_out("hold 255", 255, 1'b0);

        level = 2'd1;
        for (int i = 0; i < 8; i++)
            wait_duty("down to 127", dis1[i], i == 0 ? 2 : 4, i == 0 ? 5 : 4);
        enable = 1'b0;
        for (int i = 0; i < 8; i++)
            wait_duty("disable ramp", dis2[i], 4, 4);
        chk("disable at 0 busy", busy, 1'b1);
        @(negedge clk);
        chk_out("disable idle", 0, 1'b0);

        enable = 1'b1;
        level = 2'd1;
        @(negedge clk);
        chk_out("abort kick", 255, 1'b1);
        repeat (6) @(negedge clk);
        level = 2'd0;
        for (int i = 0; i < 16; i++)
            wait_duty("abort ramp", i == 15 ? 0 : 239 - 16 * i, i == 0 ? 1 : 4, i == 0 ? 5 : 4);
        chk("abort at 0 busy", busy, 1'b1);
        @(negedge clk);
        chk_out("abort idle", 0, 1'b0);

        level = 2'd1;
        @(negedge clk);
        chk_out("pre-reset kick", 255, 1'b1);
        wait_duty("pre-reset ramp", 239, 13, 16);
        #2 reset_n = 1'b0;
        #1 chk_out("async reset", 0, 1'b0);
        @(negedge clk);
        chk_out("async reset held", 0, 1'b0);
        level = 2'd2;
        reset_n = 1'b1;
        @(negedge clk);
        chk_out("rekick", 255, 1'b1);
        for (int i = 0; i < 6; i++)
            wait_duty("rekick ramp", lvl2[i], i == 0 ? 13 : 4, i == 0 ? 16 : 4);
        @(negedge clk);
        chk_out("rekick hold", 170, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fan_speed_ramp.md
# fan_speed_ramp

Speed-setpoint sequencer for the fan's DC motor. It sits directly upstream of the 8-bit DC-motor PWM generator and drives that generator's duty input. A 2-bit speed level and an enable become a duty value that never steps abruptly: a stopped motor first gets a full-duty kick-start, then the duty slews toward the target at a fixed rate.

## Interface
- N, 8, duty width; must match the downstream PWM width.
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- STEP_HZ, 1000, ramp tick rate in Hz; tick period = CLK_FREQ/STEP_HZ clocks, which must be ≥ 2.
- STEP, 1, duty change per tick while ramping; must be ≥ 1 and < 2^N.
- KICK_TICKS, 200, kick-start length in ticks; 0 disables the kick.
- LVL1, 85, target duty for level 1.
- LVL2, 170, target duty for level 2.
- LVL3, 255, target duty for level 3.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request; 0 forces target = 0.
- level  in  2  speed level 0..3; level 0 means stop.
- duty  out  N  registered duty to the PWM generator.
- busy  out  1  registered; 1 in KICK or RAMP.
- at_target  out  1  registered; 1 in IDLE or HOLD.

## Operation
- target = 0 if enable = 0 or level = 0; otherwise LVL1, LVL2 or LVL3. target is combinational and is sampled every clock.
- Tick prescaler:
  - Free-running counter over 0..CLK_FREQ/STEP_HZ-1.
  - tick is a 1-cycle pulse at the terminal count.
  - The counter is never restarted by state changes.
- IDLE:
  - duty = 0.
  - When target ≠ 0: go to KICK if KICK_TICKS > 0, else go to RAMP.
  - On entering KICK, duty = 2^N-1 and the kick counter is cleared, both on the same edge.
- KICK:
  - duty is held at 2^N-1.
  - The kick counter increments on each tick.
  - On the tick where it reaches KICK_TICKS, go to RAMP.
  - If target becomes 0 during KICK, go to RAMP immediately; the motor ramps down from max and is not cut.
- RAMP:
  - On each tick: if duty < target, duty = min(duty+STEP, target); if duty > target, duty = max(duty−STEP, target).
  - Arithmetic is done in N+1 bits. There is no wrap in either direction: 250+16 saturates to 255, and 5−16 floors at 0.
  - Every cycle, when duty == target: go to IDLE if target = 0, else go to HOLD.
- HOLD:
  - duty is held.
  - When target ≠ duty, go to RAMP; this covers any level change, disable, or level 0.
- A target change during RAMP takes effect on the next tick. The ramp direction may reverse mid-ramp.
- Outputs are derived from the next state and are registered together with it, so busy and at_target are never both 1 and never both 0.

## Timing
- Reset values:
  - state = IDLE, duty = 0, busy = 0, at_target = 1.
  - Prescaler count = 0, kick counter = 0.
- Reset assertion clears all outputs immediately, asynchronously, at any point mid-operation. Release is synchronous to the next clk edge.
- Response to a target change:
  - State reacts 1 clock after target changes.
  - The IDLE→KICK jump to full duty is visible 1 clock after target goes non-zero.
- Ramp update latency: duty changes on the edge following a tick. It is worst-case one tick period after the state enters RAMP.
- Kick duration: the first kick tick arrives within one tick period, so the kick lasts between KICK_TICKS−1 and KICK_TICKS full tick periods.
- Ramp length: ceil(|start−target|/STEP) ticks.
- Simultaneous events:
  - A tick and a target change on the same cycle: the ramp step uses the new target.
  - duty reaching target on a tick: the state moves to HOLD/IDLE on the following edge.

## Test plan
Bench parameters: CLK_FREQ=1000, STEP_HZ=250 (tick every 4 clocks), STEP=16, KICK_TICKS=3, LVL1/2/3 = 85/170/255.

- **Reset:** reset_n low with enable=1, level=3 → duty=0, busy=0, at_target=1. These hold for the whole time reset_n is low, and the output stays at IDLE values until the first edge after release.
- **Kick then ramp down:** from IDLE, set enable=1, level=1 → duty=255 one clock later. After 3 ticks the state enters RAMP. duty then steps 239, 223, …, 95, 85: 11 ticks, with the last step saturated at 85. The state then enters HOLD, with busy=0 and at_target=1.
- **Saturating ramp up:** in HOLD at 170, set level=3 → duty steps 186, 202, 218, 234, 250, 255 (never 10), then HOLD.
- **Disable mid-ramp:** at duty=127 ramping down, set enable=0 → duty keeps stepping down by 16 per tick to 15, then 0. The state goes to IDLE one clock after duty reaches 0, and busy falls to 0.
- **Abort during kick:** set level=0 during the 2nd kick tick → RAMP immediately. duty falls from 255 to 0 over 16 ticks, then IDLE.
- **Async reset mid-ramp:** pulse reset_n low between clock edges → duty=0 without waiting for clk. After release, with level=2, the full kick sequence repeats.
